seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Parametrised, time-multiplexed seven-segment display driver. Successor to the fixed 4-digit seg/dig output path of the project top.
- Scans DIGITS common-anode/cathode digits at a programmable refresh rate.
- Takes tear-free value updates through a load strobe; a new value is applied only at scan-frame boundaries.
- Supports per-digit decimal points and global blanking. Sits between the CPU output register and the board pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- REFRESH_DIV, 50000, clk cycles per digit slot (>=2).
- SEG_ACTIVE_LOW, 1, 1 = segment lines driven low when lit.
- DIG_ACTIVE_LOW, 1, 1 = digit enables driven low when selected.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- value  in  4*DIGITS  hex nibbles; nibble 0 (bits 3:0) = rightmost digit 0.
- dp_in  in  DIGITS  decimal point per digit; bit i lights dp of digit i.
- load  in  1  single-cycle strobe; captures value and dp_in.
- blank  in  1  level; while high all digits are deselected.
- seg  out  8  seg[0]=a .. seg[6]=g, seg[7]=dp; polarity per SEG_ACTIVE_LOW.
- dig  out  DIGITS  one-hot digit select; polarity per DIG_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse when the scan index wraps DIGITS-1 -> 0.

Behaviour:
- Reset is synchronous and active-high; clock is clk.
- State at reset: prescaler=0, idx=0, shadow=0, shadow_dp=0, pending=0, pend_valid=0.
- Outputs at reset: seg=all segments off (8'hFF when active-low), dig=all deselected, frame_done=0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler==REFRESH_DIV-1).
- On tick, idx increments; at DIGITS-1 it wraps to 0 and asserts frame_done for exactly that cycle (registered, same edge as the wrap).
- load: on the load cycle, pending<=value, pend_dp<=dp_in, pend_valid<=1. A second load before the boundary overwrites pending (last wins).
- Frame boundary (tick && idx==DIGITS-1):
  - if pend_valid: shadow<=pending, pend_valid<=0.
  - if load is high in the same cycle: the load data goes directly to shadow and pend_valid<=0.
- Outputs are registered with 1 cycle latency from idx/shadow/blank:
  - dig <= one-hot(idx), polarity-adjusted.
  - seg <= decode(shadow nibble idx) with dp = shadow_dp[idx], polarity-adjusted.
- blank=1: next cycle dig=all deselected and seg=all off. Scanning and the prescaler keep running; pending updates still apply.
- Decode: standard hex 0-F glyphs (0=abcdef, 1=bc, .. A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg).
- Reset mid-frame: all state returns to reset values next edge; a pending load is discarded.
- Widths: idx is $clog2(DIGITS) bits, minimum 1. Prescaler is $clog2(REFRESH_DIV) bits.

Optional Feature:
- Macro SEG_LEADING_ZERO_BLANK_EN.
- Defined: digits above the most significant nonzero nibble of shadow are deselected (dig inactive, seg off) unless that digit's dp bit is set. Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all DIGITS digits always shown, including leading zeros.

Decomposition:
- Package seg_pkg:
  - 16-entry hex-to-segment constant table (active-high, bit order a..g).
  - localparams SEG_OFF and DP_BIT.
- One sub-module, hex_to_seg7: combinational nibble -> 7-bit active-high pattern. Polarity inversion is done in seg_scan_display.

Test Plan (DIGITS=4, REFRESH_DIV=4, both polarities active-low):
- Hold reset 3 cycles -> dig=4'b1111, seg=8'hFF, frame_done=0. First cycle after release -> dig=4'b1110, seg=8'hC0 ("0").
- load value=16'h12AF mid-frame -> digit-0 slot still 8'hC0 until wrap; frame_done pulses once after 16 cycles from reset. Next slot: dig=4'b1110, seg=8'h8E ("F"); following slot dig=4'b1101, seg=8'h88 ("A").
- Two loads in one frame (16'h1111 then 16'h2222) -> after boundary every slot shows "2" (seg=8'hA4); "1" never appears.
- load 16'h3333 exactly on the boundary cycle -> the very next slot shows "3" (seg=8'hB0) with no extra frame delay.
- blank=1 for 10 cycles -> dig=4'b1111 and seg=8'hFF from the following cycle. frame_done keeps pulsing every 16 cycles.
- With SEG_LEADING_ZERO_BLANK_EN, load 16'h0050 -> digits 3 and 2 deselected in their slots; digit 1 seg=8'h92 ("5"); digit 0 seg=8'hC0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table (active-high, bit 0 = a)
// and the segment-off / decimal-point bit definitions.
package seg_pkg;

  // Entry 15 first so that HEX_SEG_TABLE[n] is the glyph for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam int         DP_BIT  = 7;

  function automatic logic [7:0] seg_polarity(input logic [7:0] pattern, input logic active_low);
    return active_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment pattern (bit 0 = a .. bit 6 = g).
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Table lookup; polarity is applied by the caller.
  always_comb begin
    pattern = HEX_SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment driver with frame-aligned (tear-free) value updates.
// Optional macro SEG_LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_done
);

  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int                PRE_W    = $clog2(REFRESH_DIV);
  localparam logic              SEG_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic              DIG_INV  = (DIG_ACTIVE_LOW != 0);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  logic [PRE_W-1:0]    presc_r;
  logic [IDX_W-1:0]    idx_r;
  logic [4*DIGITS-1:0] shadow_r;
  logic [DIGITS-1:0]   shadow_dp_r;
  logic [4*DIGITS-1:0] pending_r;
  logic [DIGITS-1:0]   pend_dp_r;
  logic                pend_valid_r;
  logic [7:0]          seg_r;
  logic [DIGITS-1:0]   dig_r;
  logic                frame_done_r;

  logic                tick_s;
  logic                boundary_s;
  logic [3:0]          nibble_s;
  logic                dp_s;
  logic [6:0]          glyph_s;
  logic [DIGITS-1:0]   dig_onehot_s;
  logic                show_s;

  assign tick_s     = (presc_r == PRE_LAST);
  assign boundary_s = tick_s && (idx_r == IDX_LAST);

  // Prescaler, scan index and frame pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r      <= '0;
      idx_r        <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= boundary_s;
      if (tick_s) begin
        presc_r <= '0;
        idx_r   <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
      end else begin
        presc_r <= presc_r + PRE_W'(1);
      end
    end
  end

  // Pending/shadow buffering: the shadow only changes on a frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r     <= '0;
      shadow_dp_r  <= '0;
      pending_r    <= '0;
      pend_dp_r    <= '0;
      pend_valid_r <= 1'b0;
    end else if (boundary_s) begin
      if (load) begin
        shadow_r    <= value;
        shadow_dp_r <= dp_in;
      end else if (pend_valid_r) begin
        shadow_r    <= pending_r;
        shadow_dp_r <= pend_dp_r;
      end else begin
        shadow_r    <= shadow_r;
        shadow_dp_r <= shadow_dp_r;
      end
      pend_valid_r <= 1'b0;
    end else if (load) begin
      pending_r    <= value;
      pend_dp_r    <= dp_in;
      pend_valid_r <= 1'b1;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end

  assign nibble_s = shadow_r[{idx_r, 2'b00} +: 4];
  assign dp_s     = shadow_dp_r[idx_r];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble  (nibble_s),
    .pattern (glyph_s)
  );

  // One-hot select of the digit currently being scanned.
  always_comb begin
    dig_onehot_s        = '0;
    dig_onehot_s[idx_r] = 1'b1;
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lit_s;
  logic              above_nz_s;

  // A digit is lit if it or any higher nibble is nonzero, it has a dp, or it is digit 0.
  always_comb begin
    lit_s      = '0;
    above_nz_s = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      above_nz_s = above_nz_s | (|shadow_r[4*i +: 4]);
      lit_s[i]   = above_nz_s | shadow_dp_r[i] | (i == 0);
    end
    show_s = lit_s[idx_r];
  end
`else
  // Every digit is shown, leading zeros included.
  always_comb begin
    show_s = 1'b1;
  end
`endif

  // Registered, polarity-adjusted pin drivers.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r <= seg_polarity(SEG_OFF, SEG_INV);
      dig_r <= {DIGITS{DIG_INV}};
    end else if (blank || !show_s) begin
      seg_r <= seg_polarity(SEG_OFF, SEG_INV);
      dig_r <= {DIGITS{DIG_INV}};
    end else begin
      seg_r <= seg_polarity({dp_s, glyph_s}, SEG_INV);
      dig_r <= dig_onehot_s ^ {DIGITS{DIG_INV}};
    end
  end

  assign seg        = seg_r;
  assign dig        = dig_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display (DIGITS=4, REFRESH_DIV=4, active-low pins);
// directed scenarios followed by randomized load/blank/reset traffic against a frame-level model.
module tb_seg_scan_display;

  localparam int DIGITS = 4;
  localparam int RDIV   = 4;
  localparam int FRAME  = DIGITS * RDIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_display #(
    .DIGITS         (DIGITS),
    .REFRESH_DIV    (RDIV),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .blank      (blank),
    .seg        (seg),
    .dig        (dig),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Lit segments of each hex glyph, by letter.
  string glyph_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  // Model state: edges since reset release, displayed value, and the most recent load.
  int          n_m;
  logic [15:0] shadow_m;
  logic [3:0]  shadow_dp_m;
  int          last_load_n;
  logic [15:0] last_val;
  logic [3:0]  last_dp;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_dig;
  logic        exp_fd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got=%h expected=%h", tag, n_m, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] r;
    string      s;
    int         bitpos;
    r = 7'd0;
    s = glyph_str[h];
    for (int k = 0; k < s.len(); k++) begin
      bitpos    = int'(s[k]) - 97;
      r[bitpos] = 1'b1;
    end
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int   slot;
    logic vis;
    if (reset) begin
      n_m         = 0;
      shadow_m    = 16'h0000;
      shadow_dp_m = 4'h0;
      last_load_n = -1;
      exp_seg     = 8'hFF;
      exp_dig     = 4'hF;
      exp_fd      = 1'b0;
    end else begin
      n_m++;
      slot = ((n_m - 1) / RDIV) % DIGITS;
      vis  = 1'b1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      vis = (slot == 0) || shadow_dp_m[slot] || ((shadow_m >> (4 * slot)) != 16'h0000);
`endif
      if (blank || !vis) begin
        exp_seg = 8'hFF;
        exp_dig = 4'hF;
      end else begin
        exp_seg = ~{shadow_dp_m[slot], glyph(shadow_m[4*slot +: 4])};
        exp_dig = ~(4'b0001 << slot);
      end
      exp_fd = (n_m % FRAME) == 0;
      if (load) begin
        last_load_n = n_m;
        last_val    = value;
        last_dp     = dp_in;
      end
      // At a boundary the newest load since the previous boundary (this edge included) takes effect.
      if (exp_fd && last_load_n > n_m - FRAME) begin
        shadow_m    = last_val;
        shadow_dp_m = last_dp;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("seg", {24'd0, seg}, {24'd0, exp_seg});
    check_eq("dig", {28'd0, dig}, {28'd0, exp_dig});
    check_eq("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int blank_left;
    reset = 1'b1; value = 16'h0000; dp_in = 4'h0; load = 1'b0; blank = 1'b0;
    n_m = 0; shadow_m = 16'h0000; shadow_dp_m = 4'h0; last_load_n = -1;
    last_val = 16'h0000; last_dp = 4'h0;

    repeat (3) step();
    check_eq("reset_dig", {28'd0, dig}, 32'h0000_000F);
    check_eq("reset_seg", {24'd0, seg}, 32'h0000_00FF);
    reset = 1'b0;
    step();
    check_eq("first_dig", {28'd0, dig}, 32'h0000_000E);
    check_eq("first_seg", {24'd0, seg}, 32'h0000_00C0);

    // Mid-frame load stays invisible until the wrap.
    repeat (4) step();
    do_load(16'h12AF, 4'h0);
    while (n_m < FRAME) step();
    check_eq("wrap_pulse", {31'd0, frame_done}, 32'd1);
    step();
    check_eq("slot0_F", {24'd0, seg}, 32'h0000_008E);
    repeat (RDIV) step();
    check_eq("slot1_A_dig", {28'd0, dig}, 32'h0000_000D);
    check_eq("slot1_A_seg", {24'd0, seg}, 32'h0000_0088);

    // Two loads in one frame: the last one wins.
    do_load(16'h1111, 4'h0);
    repeat (2) step();
    do_load(16'h2222, 4'h0);
    while ((n_m % FRAME) != 0) step();
    repeat (FRAME) begin
      step();
      check_eq("last_wins", {24'd0, seg}, 32'h0000_00A4);
    end

    // Load exactly on the boundary edge goes straight to the display.
    while ((n_m % FRAME) != FRAME - 1) step();
    do_load(16'h3333, 4'h0);
    step();
    check_eq("boundary_load", {24'd0, seg}, 32'h0000_00B0);

    // Blanking, with a dp-bearing value queued meanwhile.
    blank = 1'b1;
    do_load(16'hC0DE, 4'b0101);
    repeat (9) step();
    check_eq("blank_seg", {24'd0, seg}, 32'h0000_00FF);
    blank = 1'b0;
    repeat (2 * FRAME) step();

`ifdef SEG_LEADING_ZERO_BLANK_EN
    do_load(16'h0050, 4'h0);
    repeat (3 * FRAME) step();
`endif

    // Randomized traffic.
    blank_left = 0;
    for (int cyc = 0; cyc < 1800; cyc++) begin
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      dp_in = 4'($urandom);
      if (blank_left > 0) begin
        blank_left--;
      end else if ($urandom_range(0, 40) == 0) begin
        blank_left = $urandom_range(1, 12);
      end else begin
        blank_left = 0;
      end
      blank = (blank_left > 0);
      reset = ($urandom_range(0, 250) == 0);
      step();
    end
    reset = 1'b0; load = 1'b0; blank = 1'b0;
    repeat (FRAME) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
